// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_DONE} state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  state_t        state_q, state_d;
  logic          wr_ok;
  logic          pop;

  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == ST_LAUNCH);

  // FIFO datapath: accept/reject writes, pop on launch, flush clears pointers and count
  always_comb begin
    wr_ok      = wr_en && !full && !flush;
    pop        = (state_q == ST_IDLE) && !empty && !tx_busy && !flush;
    overflow_d = wr_en && full && !flush;

    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wp_q] = wr_data;
    end

    tx_data_d = pop ? mem_q[rp_q] : tx_data_q;

    if (flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      rp_d    = pop   ? rp_q + 1'b1 : rp_q;
      wp_d    = wr_ok ? wp_q + 1'b1 : wp_q;
      count_d = count_q;
      if (wr_ok && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !wr_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Launch sequencer: present a byte, hold until the transmitter takes it, wait for release
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pop)      state_d = ST_LAUNCH;
      ST_LAUNCH: if (tx_busy)  state_d = ST_DONE;
      ST_DONE:   if (!tx_busy) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any queued bytes and the pending launch immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      rp_q       <= '0;
      wp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      state_q    <= ST_IDLE;
    end else begin
      mem_q      <= mem_d;
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // transmitter stand-in
  bit         tx_auto = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] rx[$];

  // behavioural model: queue of stored bytes plus handshake phase flags
  logic [7:0] m_q[$];
  bit         m_launch = 1'b0;
  bit         m_done = 1'b0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_txd = 8'h00;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model update: bytes in arrival order, one launch at a time, handshake completes on busy rise/fall
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_launch = 1'b0;
      m_done   = 1'b0;
      m_ovf    = 1'b0;
      m_txd    = 8'h00;
    end else begin
      bit was_full;
      was_full = (m_q.size() == 16);
      m_ovf = wr_en && was_full && !flush;
      if (m_launch) begin
        if (tx_busy) begin m_launch = 1'b0; m_done = 1'b1; end
      end else if (m_done) begin
        if (!tx_busy) m_done = 1'b0;
      end else if (m_q.size() > 0 && !tx_busy && !flush) begin
        m_txd = m_q.pop_front();
        m_launch = 1'b1;
      end
      if (flush) m_q.delete();
      else if (wr_en && !was_full) m_q.push_back(wr_data);
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == 16));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("tx_start", 32'(tx_start), 32'(m_launch));
      chk("tx_data", 32'(tx_data), 32'(m_txd));
    end
  end

  task automatic tick();
    logic       s;
    logic [7:0] d;
    s = tx_start;
    d = tx_data;
    @(posedge clk);
    #1;
    if (tx_auto) begin
      if (tx_busy) begin
        if (busy_cnt > 0) busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end else if (s) begin
        rx.push_back(d);
        tx_busy = 1'b1;
        busy_cnt = 3;
      end
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 800; i++) begin
      if (m_q.size() == 0 && !m_launch && !m_done && !tx_busy) break;
      tick();
    end
    chk("drain_idle", 32'(tx_busy || !empty || tx_start), 32'd0);
  endtask

  task automatic chk_rx(input string nm, input int n, input int base);
    chk({nm, "_len"}, 32'(rx.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({nm, "_byte"}, (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'((base + i) & 8'hFF));
    end
  endtask

  initial begin
    int n;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    chk_on = 1'b1;
    tick();

    // single byte latency
    tx_auto = 1'b1;
    rx.delete();
    wr(8'hA5);
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_start_lo", 32'(tx_start), 32'd0);
    tick();
    chk("lat_start_hi", 32'(tx_start), 32'd1);
    chk("lat_data", 32'(tx_data), 32'hA5);
    chk("lat_count0", 32'(count), 32'd0);
    drain();
    chk_rx("single", 1, 8'hA5);

    // fill with transmitter stalled, then overflow
    tx_auto = 1'b0;
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    wr(8'hEE);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    rx.delete();
    tx_busy = 1'b0;
    busy_cnt = 0;
    tx_auto = 1'b1;
    drain();
    chk_rx("fill", 16, 0);

    // 40-byte stream with random gaps, wrapping pointers twice
    rx.delete();
    n = 0;
    for (int c = 0; c < 2000 && n < 40; c++) begin
      if ($urandom_range(0, 2) != 0 && m_q.size() < 16) begin
        wr(8'(n + 64));
        n++;
      end else begin
        tick();
      end
    end
    chk("stream_written", 32'(n), 32'd40);
    drain();
    chk_rx("stream", 40, 64);

    // full FIFO, rejected write on the pop cycle
    tx_auto = 1'b0;
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    chk("popfull_count", 32'(count), 32'd16);
    tx_busy = 1'b0;
    wr(8'h99);
    chk("popfull_ovf", 32'(overflow), 32'd1);
    chk("popfull_count15", 32'(count), 32'd15);
    chk("popfull_start", 32'(tx_start), 32'd1);
    chk("popfull_data", 32'(tx_data), 32'h80);
    rx.delete();
    busy_cnt = 0;
    tx_auto = 1'b1;
    drain();
    chk_rx("popfull", 16, 8'h80);

    // flush with a byte in flight and five queued
    tx_auto = 1'b0;
    tx_busy = 1'b0;
    wr(8'h3C);
    for (int i = 1; i <= 5; i++) wr(8'(8'h10 + i));
    chk("flush_pre_count", 32'(count), 32'd5);
    chk("flush_pre_start", 32'(tx_start), 32'd1);
    flush = 1'b1;
    wr(8'hFF);
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_start", 32'(tx_start), 32'd1);
    chk("flush_data", 32'(tx_data), 32'h3C);
    rx.delete();
    busy_cnt = 0;
    tx_auto = 1'b1;
    repeat (40) tick();
    chk_rx("flush", 1, 8'h3C);

    // asynchronous reset while launching
    tx_auto = 1'b0;
    tx_busy = 1'b0;
    wr(8'h5A);
    tick();
    chk("arst_pre_start", 32'(tx_start), 32'd1);
    wr_en = 1'b1;
    wr_data = 8'h77;
    reset = 1'b1;
    #1;
    chk("arst_start", 32'(tx_start), 32'd0);
    chk("arst_data", 32'(tx_data), 32'h00);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    wr_en = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_start", 32'(tx_start), 32'd0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. Host logic writes bytes at clock rate into a circular FIFO. The block pops them one at a time and drives the transmitter's `tx_data`/`tx_start` inputs. It honours `tx_busy`, so no byte is dropped or sent twice regardless of baud-tick alignment.

## Interface

- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, log2(DEPTH): pointer width, derived and not overridden.

- `clk` in 1: system clock, shared with the UART.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: enqueue strobe, one byte per cycle.
- `flush` in 1: synchronous clear of FIFO contents.
- `full` out 1: FIFO holds DEPTH bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `count` out AW+1: bytes currently stored, 0..DEPTH.
- `overflow` out 1: one-cycle pulse when a write is rejected.
- `tx_data` out 8: byte presented to the transmitter.
- `tx_start` out 1: launch request to the transmitter.
- `tx_busy` in 1: transmitter busy flag.

## Operation

- Storage: DEPTH×8 register array, with read pointer `rp` and write pointer `wp` of AW bits that wrap naturally modulo DEPTH. `count` is a separate AW+1-bit register.
- `full` = (`count` == DEPTH). `empty` = (`count` == 0). Both decode from registered `count`.
- Write accepted when `wr_en`=1, `full`=0 and `flush`=0: mem[wp] ← wr_data, wp ← wp+1.
- Write rejected when `wr_en`=1 and `full`=1 and `flush`=0: data discarded, `overflow`=1 next cycle for one cycle. This applies even if a pop occurs the same cycle, because `full` is evaluated before the pop.
- Pop: occurs only in the IDLE→LAUNCH transition. It loads `tx_data` ← mem[rp] and sets rp ← rp+1.
- `count` update per cycle: +1 for an accepted write, −1 for a pop. A simultaneous write and pop leaves `count` unchanged.
- `flush`=1: rp, wp and `count` go to 0 and any concurrent write is dropped without `overflow`. FSM state, `tx_data` and `tx_start` are unaffected, so an in-flight byte completes.
- Launch FSM:
  - IDLE: `tx_start`=0. If `empty`=0 and `tx_busy`=0 and `flush`=0, pop and go to LAUNCH.
  - LAUNCH: `tx_start`=1 and `tx_data` held stable. Hold until `tx_busy`=1 is sampled, then go to DONE. No timeout.
  - DONE: `tx_start`=0. Wait for `tx_busy`=0, then go to IDLE.
- `tx_data` changes only on a pop. It retains its last value otherwise.

## Timing

- Reset values: `tx_start`=0, `tx_data`=8'h00, `full`=0, `empty`=1, `count`=0, `overflow`=0. FSM starts in IDLE, pointers at 0.
- Reset mid-transfer: everything returns to reset values immediately and the queued bytes are lost. The transmitter shares `reset`, so no handshake is pending afterwards.
- Write-to-launch latency into an empty FIFO with the transmitter idle:
  - write sampled at edge N;
  - `count`=1 after N;
  - pop at edge N+1, with `tx_start`=1 and the new `tx_data` visible after N+1.
- `tx_start` stays high from LAUNCH entry through the edge at which `tx_busy`=1 is sampled, so it is at least 1 cycle wide.
- Back-to-back bytes: the next pop happens on the first edge where the FSM is in IDLE with `tx_busy`=0. The minimum gap between `tx_start` deassertion and the next assertion is 2 cycles: DONE→IDLE, then IDLE→LAUNCH.
- FIFO throughput is 1 write per cycle, independent of drain rate. `full` and `count` reflect an edge's write on the following cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no special case. Byte order is strictly preserved.

## Test plan

- Reset with the transmitter idle; write 8'hA5 at cycle 5 → `tx_start` rises after edge 6 with `tx_data`=8'hA5 and `count` returns to 0. Serial output frames 0xA5.
- Write 16 bytes 8'h00..8'h0F back-to-back with the transmitter stalled (`tx_busy` held 1) → `full`=1 and `count`=16. A 17th write gives `overflow` pulsed for exactly 1 cycle, `count` stays 16, and the later drain order is 00..0F.
- Stream 40 bytes with random `wr_en` gaps and the real transmitter attached → all 40 bytes are received in order through two pointer wraps, with no duplicate `tx_start` per byte.
- With `count`=16, assert `wr_en` on the cycle the FSM pops → write rejected, `overflow`=1, `count`=15.
- While byte 8'h3C is in flight with 5 queued, pulse `flush` together with `wr_en` → 0x3C completes, `count`=0, `empty`=1, `overflow`=0, and no further `tx_start`.
- Assert `reset` while in LAUNCH → `tx_start`=0, `tx_data`=0 and `empty`=1 immediately, without waiting for a clock edge.
